// File: rtl/seq_pattern_detector_if.sv
// Serial lane + configuration bundle for seq_pattern_detector.
// The master drives the stream and config; the slave (detector) returns o_find/o_count.
interface seq_pattern_detector_if #(
  parameter int PAT_W = 16,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int CNT_W = 8
);
  // Handshake: i_data is consumed on every rising edge where i_valid=1 and i_cfg_load=0.
  // The detector always accepts, so there is no ready/backpressure path.
  logic             i_valid;
  logic             i_data;
  logic             i_cfg_load;
  logic [PAT_W-1:0] i_pattern;
  logic [LEN_W-1:0] i_len;
  logic             i_overlap;
  logic             o_find;
  logic [CNT_W-1:0] o_count;

  modport master (
    output i_valid, i_data, i_cfg_load, i_pattern, i_len, i_overlap,
    input  o_find, o_count
  );

  modport slave (
    input  i_valid, i_data, i_cfg_load, i_pattern, i_len, i_overlap,
    output o_find, o_count
  );
endinterface

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector with overlap/non-overlap matching.
// Define SEQDET_MATCH_CNT_EN to build the saturating match counter; otherwise o_count is 0.
module seq_pattern_detector #(
  parameter int PAT_W = 16,
  parameter int CNT_W = 8
) (
  input logic                   i_clk,
  input logic                   i_rst,
  seq_pattern_detector_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d, hist_shift, mask;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc;
  logic             ovl_q, ovl_d;
  logic             find_q, find_d;
  logic             accept, len_ok, match;

  assign accept     = bus.i_valid & ~bus.i_cfg_load;
  assign hist_shift = {hist_q[PAT_W-2:0], bus.i_data};
  // Out-of-range lengths never match rather than being truncated to PAT_W.
  assign len_ok     = (len_q != '0) && (int'(len_q) <= PAT_W);
  assign fill_inc   = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  assign match = accept && len_ok && (fill_inc >= len_q) &&
                 (((hist_shift ^ pat_q) & mask) == '0);

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    find_d = match;
    if (bus.i_cfg_load) begin
      pat_d  = bus.i_pattern;
      len_d  = bus.i_len;
      ovl_d  = bus.i_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.i_valid) begin
      hist_d = hist_shift;
      fill_d = (match && !ovl_q) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pat_q  <= '0;
      len_q  <= '0;
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      find_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      find_q <= find_d;
    end
  end

  assign bus.o_find = find_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_cfg_load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_count = cnt_q;
`else
  assign bus.o_count = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed vector table, then random traffic against
// a bit-queue reference model. Two DUTs (CNT_W=8 and CNT_W=2) share the stimulus.
module tb_seq_pattern_detector;
  localparam int PAT_W = 16;
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef struct {
    logic             rst;
    logic             load;
    logic             valid;
    logic             data;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ovl;
    logic             find;
    int               cnt;   // expected CNT_W=8 count after this cycle, -1 = unchecked
  } vec_t;

  // ---------------- clock / reset / stimulus signals ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             valid, data, load, ovl;
  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;

  always #5 clk = ~clk;

  seq_pattern_detector_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(8)) bus_a ();
  seq_pattern_detector_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) bus_b ();

  assign bus_a.i_valid    = valid;
  assign bus_a.i_data     = data;
  assign bus_a.i_cfg_load = load;
  assign bus_a.i_pattern  = pat;
  assign bus_a.i_len      = len;
  assign bus_a.i_overlap  = ovl;
  assign bus_b.i_valid    = valid;
  assign bus_b.i_data     = data;
  assign bus_b.i_cfg_load = load;
  assign bus_b.i_pattern  = pat;
  assign bus_b.i_len      = len;
  assign bus_b.i_overlap  = ovl;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.slave)
  );

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.slave)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // Keeps the recent accepted bits as a queue and the number of bits usable for a match.
  bit               m_bits[$];
  int               m_avail;
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  bit               m_ovl;
  bit               m_find;
  int               m_cnt8, m_cnt2;

  function automatic void model_step(bit r, bit l, bit v, bit d,
                                     logic [PAT_W-1:0] p, int n, bit o);
    bit hit;
    if (r) begin
      m_bits.delete(); m_avail = 0; m_pat = '0; m_len = 0; m_ovl = 1'b1;
      m_find = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (l) begin
      m_pat = p; m_len = n; m_ovl = o;
      m_bits.delete(); m_avail = 0; m_find = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      m_avail++;
      hit = (m_len >= 1) && (m_len <= PAT_W) && (m_avail >= m_len);
      if (hit) begin
        for (int k = 0; k < m_len; k++) begin
          if (m_bits[m_bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
        end
      end
      m_find = hit;
      if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
        if (!m_ovl) m_avail = 0;
      end
    end else begin
      m_find = 1'b0;
    end
  endfunction

  function automatic int exp_count(int c, int sat);
`ifdef SEQDET_MATCH_CNT_EN
    return (c > sat) ? sat : c;
`else
    return 0;
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic run_cycle(input vec_t v, input bit from_table);
    rst = v.rst; load = v.load; valid = v.valid; data = v.data;
    pat = v.pat; len = v.len; ovl = v.ovl;
    @(posedge clk);
    model_step(v.rst, v.load, v.valid, v.data, v.pat, int'(v.len), v.ovl);
    @(negedge clk);
    check("find_a", 32'(bus_a.o_find), 32'(m_find));
    check("find_b", 32'(bus_b.o_find), 32'(m_find));
    check("cnt_a", 32'(bus_a.o_count), 32'(exp_count(m_cnt8, 255)));
    check("cnt_b", 32'(bus_b.o_count), 32'(exp_count(m_cnt2, 3)));
    if (from_table) begin
      check("tbl_find", 32'(bus_a.o_find), 32'(v.find));
      if (v.cnt >= 0) begin
        check("tbl_cnt8", 32'(bus_a.o_count), 32'(exp_count(v.cnt, 255)));
        check("tbl_cnt2", 32'(bus_b.o_count), 32'(exp_count(v.cnt, 3)));
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  vec_t vecs[$];

  function automatic void add(bit r, bit l, bit v, bit d, logic [PAT_W-1:0] p,
                              logic [LEN_W-1:0] n, bit o, bit f);
    vecs.push_back('{r, l, v, d, p, n, o, f, -1});
  endfunction

  // Load cycles present a valid 1 that must be discarded.
  function automatic void add_load(logic [PAT_W-1:0] p, logic [LEN_W-1:0] n, bit o);
    add(1'b0, 1'b1, 1'b1, 1'b1, p, n, o, 1'b0);
  endfunction

  // bits[n-1] is sent first; finds[i] is the expected o_find after bits[i].
  function automatic void add_stream(logic [31:0] bits, int n, logic [31:0] finds);
    for (int i = n - 1; i >= 0; i--) add(1'b0, 1'b0, 1'b1, bits[i], '0, '0, 1'b0, finds[i]);
  endfunction

  function automatic void add_rand_bits(int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), '0, '0, 1'b0, 1'b0);
  endfunction

  function automatic void set_cnt(int c);
    vecs[vecs.size() - 1].cnt = c;
  endfunction

  function automatic void build_table();
    add(1'b1, 1'b0, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0); set_cnt(0);
    // overlapping 1101101
    add_load(16'h006D, 5'd7, 1'b1);
    add_stream(32'b1101101101101, 13, 32'b0000001001001); set_cnt(3);
    // non-overlapping, then a second occurrence
    add_load(16'h006D, 5'd7, 1'b0);
    add_stream(32'b1101101101101, 13, 32'b0000001000000); set_cnt(1);
    add_stream(32'b1101101, 7, 32'b0000001); set_cnt(2);
    // valid gaps
    add_load(16'h006D, 5'd7, 1'b1);
    add_stream(32'b110, 3, 32'b000);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    add_stream(32'b1101, 4, 32'b0001); set_cnt(1);
    // reset mid-pattern
    add_load(16'h006D, 5'd7, 1'b1);
    add_stream(32'b110110, 6, 32'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, '0, '0, 1'b0, 1'b0); set_cnt(0);
    add_load(16'h006D, 5'd7, 1'b1);
    add_stream(32'b1, 1, 32'b0); set_cnt(0);
    // cfg load mid-pattern
    add_stream(32'b110110, 6, 32'b0);
    add_load(16'h006D, 5'd7, 1'b1); set_cnt(0);
    add_stream(32'b1, 1, 32'b0); set_cnt(0);
    // len 1 saturation
    add_load(16'h0001, 5'd1, 1'b1);
    add_stream(32'b11111, 5, 32'b11111); set_cnt(5);
    // periodic "11": overlap then non-overlap
    add_load(16'h0003, 5'd2, 1'b1);
    add_stream(32'b11111, 5, 32'b01111); set_cnt(4);
    add_load(16'h0003, 5'd2, 1'b0);
    add_stream(32'b11111, 5, 32'b01010); set_cnt(2);
    // full-width pattern
    add_load(16'hA5C3, 5'd16, 1'b1);
    add_stream(32'h0000A5C3, 16, 32'h00000001); set_cnt(1);
    // never-match lengths
    add_load(16'($urandom), 5'd0, 1'b1);
    add_rand_bits(20); set_cnt(0);
    add_load(16'($urandom), 5'(PAT_W + 1), 1'b1);
    add_rand_bits(20); set_cnt(0);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t v;
    rst = 1'b1; load = 1'b0; valid = 1'b0; data = 1'b0;
    pat = '0; len = '0; ovl = 1'b0;
    build_table();
    @(negedge clk);

    foreach (vecs[i]) run_cycle(vecs[i], 1'b1);

    // random traffic, short patterns so matches are frequent
    for (int c = 0; c < 3000; c++) begin
      v.rst   = ($urandom_range(0, 299) == 0);
      v.load  = ($urandom_range(0, 49) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.data  = 1'($urandom_range(0, 1));
      v.pat   = 16'($urandom);
      v.len   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 17))
                                            : 5'($urandom_range(1, 4));
      v.ovl   = 1'($urandom_range(0, 1));
      v.find  = 1'b0;
      v.cnt   = -1;
      run_cycle(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial bit-pattern detector: the next generation of the team's fixed-sequence detector FSM. It has a runtime-programmable pattern and length, selectable overlapping or non-overlapping matching, a valid qualifier on the input stream, and an optional saturating match counter. It sits on a serial data lane and flags each completed occurrence of the programmed pattern to downstream control logic.

## Interface
- PAT_W, 16, maximum pattern length in bits (≥2)
- LEN_W, $clog2(PAT_W+1), width of length field (derived; do not override)
- CNT_W, 8, match counter width
- i_clk  input  1  clock; all logic rising-edge
- i_rst  input  1  reset, synchronous, active-high
- i_valid  input  1  i_data is sampled only when high
- i_data  input  1  serial data bit
- i_cfg_load  input  1  latch i_pattern/i_len/i_overlap; clears match history
- i_pattern  input  PAT_W  pattern; bit [len-1] is first-received, bit [0] last-received
- i_len  input  LEN_W  active pattern length, 1..PAT_W
- i_overlap  input  1  1 = overlapping matches, 0 = non-overlapping
- o_find  output  1  one-cycle match pulse, registered
- o_count  output  CNT_W  saturating count of matches since reset/cfg load

## Operation
- Config registers: pat_r, len_r, ovl_r. Loaded only on i_cfg_load. Reset values: pat_r=0, len_r=0, ovl_r=1.
- History: hist (PAT_W bits). On an accepted bit (i_valid=1, no cfg load), hist ← {hist[PAT_W-2:0], i_data}.
- Fill counter: fill (LEN_W bits) counts accepted bits since the last clear and saturates at len_r.
- Match condition on an accepted bit, evaluated on next-state values: len_r≠0, fill_next ≥ len_r, and (hist_next & mask) == (pat_r & mask), where mask = the low len_r bits set.
- On a match:
  - o_find ← 1.
  - o_count increments, saturating at 2^CNT_W−1.
  - If ovl_r=0, fill is cleared to 0 so that no bit of the matched occurrence is reused. hist is still shifted.
  - If ovl_r=1, fill is unchanged.
- len_r=0 or len_r>PAT_W: no match ever. Out-of-range len is clamped to "never match". It is not truncated.
- i_cfg_load has priority over data.
  - Same cycle: config is latched; hist, fill, o_count and o_find are cleared.
  - The i_data bit presented in that cycle is discarded.
- i_valid=0: hist, fill and o_count hold; o_find ← 0.
- i_rst has top priority: hist=0, fill=0, all config registers at their reset values, o_find=0, o_count=0.

## Timing
- Latency: o_find rises in the cycle after the rising edge that samples the last pattern bit. It is high for exactly one cycle per match.
- Back-to-back matches are possible in overlap mode when the pattern is periodic (e.g. pattern "11", len 2, stream of 1s gives o_find high on every accepted bit from the 2nd onward).
- o_count updates on the same edge as o_find.
- Reset mid-pattern: a partial match is discarded. The next match needs a full len_r accepted bits after reset and a reprogram.
- Config is static between loads. i_pattern, i_len and i_overlap are don't-care when i_cfg_load=0.

## Configuration
- SEQDET_MATCH_CNT_EN defined: the CNT_W-bit saturating counter is built as described above.
- SEQDET_MATCH_CNT_EN undefined: no counter flops; o_count is tied to 0. o_find behaviour is identical in both builds.

## Test plan
- Overlap: load pattern 7'b1101101, len 7, overlap 1. Stream 1101101101101 with i_valid=1 → o_find pulses after bits 7, 10 and 13; o_count=3.
- Non-overlap: same pattern, overlap 0, same stream → single pulse after bit 7; o_count=1. Then stream 1101101 → pulse after its 7th bit; o_count=2.
- Valid gaps: overlap config. Stream 1101101 with i_valid deasserted for 3 cycles between bits 3 and 4 → exactly one pulse, after bit 7. o_find stays 0 during gaps.
- Reset/cfg mid-pattern: feed 110110, assert i_rst for one cycle, reload config, feed 1 → no pulse. Repeat using i_cfg_load instead of i_rst → no pulse; o_count=0.
- Saturation and length edges: CNT_W=2, pattern "1", len 1, 5 accepted 1s → 5 pulses; o_count saturates at 3. With len 0 or len PAT_W+1, 20 random bits → no pulses.
- Build without SEQDET_MATCH_CNT_EN: rerun the overlap test → identical o_find pulses; o_count=0 throughout.
